store_result_monitor: RTL and testbench

- Synthesizable checker that sits directly downstream of the pipelined MIPS top.
- Consumes the top's data-memory store stream: memwrite, dataadr and writedata.
- Classifies every store against a pass/allowed address set and latches a sticky verdict.
- Exposes counters for bench, FPGA LEDs or ILA. It replaces ad-hoc `$display` checking with a cycle-exact pass/fail/timeout result.

---
 rtl/mips_sim_pkg.sv | 40 ++++
 rtl/store_result_monitor_if.sv | 12 +
 rtl/store_log_buf.sv | 56 +++++
 rtl/store_result_monitor.sv | 142 ++++++++++++++
 tb/tb_store_result_monitor.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_sim_pkg.sv
// Shared types and defaults for the store result monitor that sits behind
// the pipelined MIPS top. Optional store logging is enabled by STORE_LOG_EN.
package mips_sim_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } monitor_state_t;

    localparam logic [31:0] DEF_PASS_ADDR   = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA   = 32'd7;
    localparam logic [31:0] DEF_ALLOW_ADDR  = 32'd80;
    localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd2000;
    localparam int          DEF_CNT_W       = 16;

    localparam int LOG_DEPTH = 8;
    localparam int LOG_PTR_W = $clog2(LOG_DEPTH);

    // Priority classification of one store seen while running.
    // An unknown address matches neither compare and falls through to FAIL.
    function automatic monitor_state_t classifyStore(
        input logic [31:0] adr,
        input logic [31:0] data,
        input logic [31:0] passAdr,
        input logic [31:0] passData,
        input logic [31:0] allowAdr
    );
        if (adr == passAdr) begin
            return (data == passData) ? PASS : FAIL;
        end else if (adr == allowAdr) begin
            return RUN;
        end else begin
            return FAIL;
        end
    endfunction

endpackage

// File: rtl/store_result_monitor_if.sv
// Store stream from the CPU memory stage into the result monitor.
interface store_result_monitor_if;
    // memwrite acts as a valid with no ready: the monitor never stalls the
    // CPU, so every clock edge with memwrite=1 is exactly one store, and
    // dataadr/writedata are only meaningful while memwrite is high.
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    modport master (output memwrite, output dataadr, output writedata);
    modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/store_log_buf.sv
// Circular log of the most recent stores accepted while running.
// Only instantiated when STORE_LOG_EN is defined.
module store_log_buf
    import mips_sim_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 wrEn,
    input  logic [31:0]          wrAddr,
    input  logic [31:0]          wrData,
    input  logic [LOG_PTR_W-1:0] rdIdx,
    output logic [31:0]          rdAddr,
    output logic [31:0]          rdData,
    output logic                 rdValid
);

    logic [31:0]          addrMem [LOG_DEPTH];
    logic [31:0]          dataMem [LOG_DEPTH];
    logic [LOG_DEPTH-1:0] validMem;
    logic [LOG_PTR_W-1:0] wrPtr;
    logic [LOG_PTR_W-1:0] rdPtr;

    // Write the next slot and advance the pointer; reset or start wipes the log.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr    <= '0;
            validMem <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) begin
                addrMem[i] <= '0;
                dataMem[i] <= '0;
            end
        end else if (clear) begin
            wrPtr    <= '0;
            validMem <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) begin
                addrMem[i] <= '0;
                dataMem[i] <= '0;
            end
        end else if (wrEn) begin
            addrMem[wrPtr]  <= wrAddr;
            dataMem[wrPtr]  <= wrData;
            validMem[wrPtr] <= 1'b1;
            wrPtr           <= wrPtr + 1'b1;
        end
    end

    // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
    always_comb begin
        rdPtr   = wrPtr - LOG_PTR_W'(1) - rdIdx;
        rdAddr  = addrMem[rdPtr];
        rdData  = dataMem[rdPtr];
        rdValid = validMem[rdPtr];
    end

endmodule

// File: rtl/store_result_monitor.sv
// Store result monitor: watches the MIPS store stream, classifies each store
// against the pass/allowed addresses and latches a sticky pass/fail/timeout
// verdict with saturating store and cycle counters.
// Optional feature macro: STORE_LOG_EN adds an 8-entry store log read port.
module store_result_monitor
    import mips_sim_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR   = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter logic [31:0] ALLOW_ADDR  = DEF_ALLOW_ADDR,
    parameter logic [31:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    store_result_monitor_if.slave  st,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [CNT_W-1:0]       store_count,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [31:0]            fail_addr,
    output logic [31:0]            fail_data,
    output monitor_state_t         monState
`ifdef STORE_LOG_EN
    ,
    input  logic [2:0]             log_idx,
    output logic [31:0]            log_addr,
    output logic [31:0]            log_data,
    output logic                   log_valid
`endif
);

    // Counter value seen in the last RUN cycle before a timeout is declared.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);

    monitor_state_t state;
    monitor_state_t stateNext;
    logic           clrRun;
    logic           storeHit;
    logic           captureFail;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state plus the strobes that steer counters and failure capture.
    always_comb begin
        stateNext   = state;
        clrRun      = 1'b0;
        storeHit    = 1'b0;
        captureFail = 1'b0;
        case (state)
            IDLE: begin
                // A store arriving together with start is not classified.
                if (start) begin
                    stateNext = RUN;
                    clrRun    = 1'b1;
                end
            end
            RUN: begin
                if (st.memwrite) begin
                    storeHit  = 1'b1;
                    stateNext = classifyStore(st.dataadr, st.writedata,
                                              PASS_ADDR, PASS_DATA, ALLOW_ADDR);
                end
                // A verdict store in the final cycle beats the timeout.
                if (stateNext == RUN && cycle_count == TIMEOUT_LAST) begin
                    stateNext = TIMEOUT;
                end
                captureFail = (stateNext == FAIL);
            end
            PASS, FAIL, TIMEOUT: begin
                if (start) begin
                    stateNext = RUN;
                    clrRun    = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Saturating counters and first-offender capture; cleared on every start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store_count <= '0;
            cycle_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else if (clrRun) begin
            store_count <= '0;
            cycle_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else if (state == RUN) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (storeHit && store_count != '1) begin
                store_count <= store_count + 1'b1;
            end
            if (captureFail) begin
                fail_addr <= st.dataadr;
                fail_data <= st.writedata;
            end
        end
    end

    // Verdict flags decode straight from the registered state.
    always_comb begin
        pass     = (state == PASS);
        fail     = (state == FAIL);
        timeout  = (state == TIMEOUT);
        done     = pass | fail | timeout;
        monState = state;
    end

`ifdef STORE_LOG_EN
    store_log_buf u_log (
        .clk     (clk),
        .rst     (rst),
        .clear   (clrRun),
        .wrEn    (storeHit),
        .wrAddr  (st.dataadr),
        .wrData  (st.writedata),
        .rdIdx   (log_idx),
        .rdAddr  (log_addr),
        .rdData  (log_data),
        .rdValid (log_valid)
    );
`endif

endmodule

// File: tb/tb_store_result_monitor.sv
// Directed bench for store_result_monitor (timeout shortened to 10 cycles).
// Store log checks run only when STORE_LOG_EN is defined.
module tb_store_result_monitor;
    import mips_sim_pkg::*;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [CNT_W-1:0]  store_count;
    logic [CNT_W-1:0]  cycle_count;
    logic [31:0]       fail_addr;
    logic [31:0]       fail_data;
    monitor_state_t    monState;
`ifdef STORE_LOG_EN
    logic [2:0]        log_idx = 3'd0;
    logic [31:0]       log_addr;
    logic [31:0]       log_data;
    logic              log_valid;
    logic [31:0]       exp_q[$];
`endif

    int checks = 0;
    int errors = 0;

    store_result_monitor_if bus ();

    store_result_monitor #(
        .TIMEOUT_CYC (32'd10),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .st          (bus),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .store_count (store_count),
        .cycle_count (cycle_count),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data),
        .monState    (monState)
`ifdef STORE_LOG_EN
        ,
        .log_idx     (log_idx),
        .log_addr    (log_addr),
        .log_data    (log_data),
        .log_valid   (log_valid)
`endif
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic           start;
        logic           mw;
        logic [31:0]    adr;
        logic [31:0]    data;
        monitor_state_t expState;
        int             expSc;
        int             expCc;
        logic [31:0]    expFa;
        logic [31:0]    expFd;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic mw, input logic [31:0] adr, input logic [31:0] data);
        start         = st;
        bus.memwrite  = mw;
        bus.dataadr   = adr;
        bus.writedata = data;
    endtask

    task automatic checkOut(input string tag, input monitor_state_t es, input int sc, input int cc,
                            input logic [31:0] fa, input logic [31:0] fd, input logic chkFa);
        check({tag, ".state"},   64'(monState), 64'(es));
        check({tag, ".pass"},    64'(pass),     64'(es == PASS));
        check({tag, ".fail"},    64'(fail),     64'(es == FAIL));
        check({tag, ".timeout"}, 64'(timeout),  64'(es == TIMEOUT));
        check({tag, ".done"},    64'(done),     64'(es == PASS || es == FAIL || es == TIMEOUT));
        check({tag, ".store_count"}, 64'(store_count), 64'(sc));
        check({tag, ".cycle_count"}, 64'(cycle_count), 64'(cc));
        if (chkFa) check({tag, ".fail_addr"}, 64'(fail_addr), 64'(fa));
        check({tag, ".fail_data"}, 64'(fail_data), 64'(fd));
    endtask

    initial begin
        // Vector table: inputs for one edge, then expected outputs after it.
        vecs[0]  = '{1'b1, 1'b0, 32'd0,   32'd0, RUN,  0, 0, 32'd0,   32'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'd80,  32'd5, RUN,  1, 1, 32'd0,   32'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'd80,  32'd9, RUN,  2, 2, 32'd0,   32'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'd84,  32'd7, PASS, 3, 3, 32'd0,   32'd0};
        vecs[4]  = '{1'b0, 1'b0, 32'd0,   32'd0, PASS, 3, 3, 32'd0,   32'd0};
        vecs[5]  = '{1'b1, 1'b0, 32'd0,   32'd0, RUN,  0, 0, 32'd0,   32'd0};
        vecs[6]  = '{1'b0, 1'b1, 32'd84,  32'd6, FAIL, 1, 1, 32'd84,  32'd6};
        vecs[7]  = '{1'b1, 1'b0, 32'd0,   32'd0, RUN,  0, 0, 32'd0,   32'd0};
        vecs[8]  = '{1'b0, 1'b1, 32'd100, 32'd7, FAIL, 1, 1, 32'd100, 32'd7};
        vecs[9]  = '{1'b0, 1'b1, 32'd84,  32'd7, FAIL, 1, 1, 32'd100, 32'd7};
        vecs[10] = '{1'b1, 1'b0, 32'd0,   32'd0, RUN,  0, 0, 32'd0,   32'd0};
        vecs[11] = '{1'b1, 1'b1, 32'd80,  32'd1, RUN,  1, 1, 32'd0,   32'd0};
        vecs[12] = '{1'b0, 1'b0, 32'd0,   32'd0, RUN,  1, 2, 32'd0,   32'd0};
        vecs[13] = '{1'b0, 1'b1, 32'd84,  32'd7, PASS, 2, 3, 32'd0,   32'd0};
        vecs[14] = '{1'b1, 1'b1, 32'd100, 32'd7, RUN,  0, 0, 32'd0,   32'd0};
        vecs[15] = '{1'b0, 1'b1, 32'd84,  32'd7, PASS, 1, 1, 32'd0,   32'd0};

        // Reset state.
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        checkOut("reset", IDLE, 0, 0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Stores while idle are ignored.
        drive(1'b0, 1'b1, 32'd84, 32'd7);
        tick();
        checkOut("idle_store", IDLE, 0, 0, 32'd0, 32'd0, 1'b1);

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].start, vecs[i].mw, vecs[i].adr, vecs[i].data);
            tick();
            checkOut($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expSc, vecs[i].expCc,
                     vecs[i].expFa, vecs[i].expFd, 1'b1);
        end

        // Unknown address on a store counts as a failure.
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'hxxxx_xxxx, 32'd3);
        tick();
        checkOut("x_addr", FAIL, 1, 1, 32'd0, 32'd3, 1'b0);

        // Timeout after exactly 10 RUN cycles.
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        checkOut("to_start", RUN, 0, 0, 32'd0, 32'd0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            checkOut($sformatf("to_run%0d", i), RUN, 0, i, 32'd0, 32'd0, 1'b1);
        end
        tick();
        checkOut("to_hit", TIMEOUT, 0, 10, 32'd0, 32'd0, 1'b1);
        tick();
        checkOut("to_hold", TIMEOUT, 0, 10, 32'd0, 32'd0, 1'b1);

        // Pass store in the final cycle wins over timeout.
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i <= 9; i++) tick();
        drive(1'b0, 1'b1, 32'd84, 32'd7);
        tick();
        checkOut("to_pass_wins", PASS, 1, 10, 32'd0, 32'd0, 1'b1);

        // An allowed store in the final cycle is not a verdict.
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i <= 9; i++) tick();
        drive(1'b0, 1'b1, 32'd80, 32'd4);
        tick();
        checkOut("to_allow", TIMEOUT, 1, 10, 32'd0, 32'd0, 1'b1);

        // Asynchronous reset in the middle of a run.
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'd80, 32'd1);
        tick();
        drive(1'b0, 1'b1, 32'd80, 32'd2);
        tick();
        checkOut("pre_rst", RUN, 2, 2, 32'd0, 32'd0, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        checkOut("async_rst", IDLE, 0, 0, 32'd0, 32'd0, 1'b1);
        drive(1'b0, 1'b1, 32'd84, 32'd7);
        tick();
        checkOut("rst_held", IDLE, 0, 0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checkOut("post_rst", IDLE, 0, 0, 32'd0, 32'd0, 1'b1);

`ifdef STORE_LOG_EN
        // Ten logged stores wrap the eight-entry log.
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        check("log_empty_valid", 64'(log_valid), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, 32'd80, 32'(i));
            exp_q.push_back(32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checkOut("log_run", TIMEOUT, 10, 10, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            log_idx = 3'(i);
            #1;
            check($sformatf("log_data%0d", i),  64'(log_data),  64'(exp_q[exp_q.size() - 1 - i]));
            check($sformatf("log_addr%0d", i),  64'(log_addr),  64'd80);
            check($sformatf("log_valid%0d", i), 64'(log_valid), 64'd1);
        end
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            log_idx = 3'(i);
            #1;
            check($sformatf("log_clr_valid%0d", i), 64'(log_valid), 64'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
